pr_dma_initiator: RTL and testbench
===================================

Name: pr_dma_initiator

Overview:
- Bus initiator on the CPU-side peripheral (Pr) bus. Word-copy engine: reads a word from a source device register and writes it to a destination register, repeating for a programmed count.
- Drives PrAddr/PrWD/PrWe toward the bridge exactly as the CPU does and samples PrRD. This makes it the initiator end of the interface that Timer-class devices answer.
- Raises a level IRQ on completion, intended for a spare HWInt line (HWInt[13]).

Parameters:
- LEN_W, 16, width of the word-count field. Maximum transfer is 2^LEN_W-1 words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse. Sampled only in IDLE.
- src_addr  in  32  source byte address. Bits [1:0] are ignored.
- dst_addr  in  32  destination byte address. Bits [1:0] are ignored.
- len  in  LEN_W  number of words to copy.
- irq_clr  in  1  clears irq.
- PrAddr  out  32  bus address, word aligned.
- PrWD  out  32  bus write data.
- PrWe  out  1  bus write enable. One cycle per write.
- PrRD  in  32  bus read data, combinational from PrAddr, valid in the same cycle.
- busy  out  1  high in every state except IDLE.
- irq  out  1  completion interrupt, level.
- words_done  out  LEN_W  words written so far in the current or last transfer.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; PrAddr=0, PrWD=0, PrWe=0, busy=0, irq=0, words_done=0; internal src/dst/remaining/data registers=0.
- FSM states: IDLE, RD, WR, FIN.
- IDLE:
  - Outputs PrAddr=0, PrWe=0.
  - On start: latch src={src_addr[31:2],2'b00}, dst likewise, rem=len; clear words_done.
  - If len!=0, go to RD. If len==0, go to FIN (zero-length transfer still completes and interrupts).
- RD:
  - PrAddr=src, PrWe=0.
  - At the clock edge: data<=PrRD, src<=src+4, go to WR.
- WR:
  - PrAddr=dst, PrWD=data, PrWe=1.
  - At the clock edge: dst<=dst+4, rem<=rem-1, words_done<=words_done+1.
  - If rem==1, go to FIN; otherwise go to RD.
- FIN:
  - PrWe=0.
  - Sets irq<=1 and returns to IDLE next cycle. FIN lasts exactly one cycle.
- Timing:
  - Throughput is 2 cycles per word.
  - Latency from the start edge to irq high is 2*len+1 cycles (len=0 gives 1 cycle).
- PrAddr/PrWD/PrWe are combinational from the state and registers. They are glitch-free relative to clk because all inputs are registered.
- Address arithmetic: 32-bit, modulo 2^32. 0xFFFFFFFC+4 wraps to 0x00000000 without error.
- start while busy: ignored. Command inputs are not relatched.
- irq:
  - Stays set until an irq_clr cycle.
  - If irq_clr and the FIN set occur in the same cycle, set wins (irq stays 1).
  - irq_clr in IDLE with irq=0 has no effect.
- Asynchronous reset mid-transfer aborts immediately. PrWe drops in the same cycle, with no partial write completed after reset assertion.
- words_done holds its final value after FIN until the next accepted start.

Optional Feature:
- Macro: PR_DMA_FILL_EN.
- When defined:
  - Extra input port fill (1 bit) and fill_val (32 bits), latched at start.
  - With fill=1, the RD state is skipped: IDLE goes to WR, and WR goes to WR while rem>1. The engine writes fill_val to every destination word at 1 cycle per word, and PrAddr never presents a source address. Latency to irq is len+1.
  - fill=0 behaves as a normal copy.
- When undefined: the ports are absent and only copy mode exists.

Decomposition:
- Shared package/header: state encoding localparams (IDLE=2'd0, RD=2'd1, WR=2'd2, FIN=2'd3), WORD_BYTES=4, and the HWInt bit index assignment (DMA_IRQ_BIT=13) used by the top level.
- No sub-module. The FSM, counters and address registers stay in one module.

Test Plan:
- Copy len=3, src=0x7F00, dst=0x7F10, with a responder model returning 0xA0+offset -> writes 0xA0@0x7F10, 0xA4@0x7F14, 0xA8@0x7F18 on cycles 2, 4 and 6 after start; irq at cycle 7; words_done=3.
- len=0 -> no PrWe pulse; irq high 1 cycle after start; words_done=0.
- src=0xFFFFFFFC, dst=0x7F04, src_addr[1:0]=2'b11, len=2 -> second read at PrAddr=0x00000000; the misaligned low bits are ignored.
- Second start pulse during busy, then irq_clr in the same cycle as FIN -> the second command is ignored; irq=1 after FIN; the next irq_clr drops it.
- reset driven low during the WR of word 2 of 4 -> PrWe=0 and all outputs at reset values before the next edge; exactly 1 write observed.
- (PR_DMA_FILL_EN) fill=1, fill_val=0xDEADBEEF, len=4, dst=0x7F00 -> 4 consecutive PrWe cycles at 0x7F00..0x7F0C with no reads; irq at cycle 5.

Source files
------------

// File: rtl/pr_dma_initiator_pkg.sv
// Shared definitions for the Pr-bus DMA word-copy initiator.
// Holds the FSM encoding, the bus word size and the HWInt line that the
// completion interrupt is wired to at the system level.
package pr_dma_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam int WORD_BYTES  = 4;
    localparam int DMA_IRQ_BIT = 13;

endpackage

// File: rtl/pr_dma_initiator.sv
// Pr-bus DMA initiator: copies len words from src to dst, one read and one
// write per word, then raises a level interrupt (intended for HWInt[13]).
// Optional build macro PR_DMA_FILL_EN adds a fill mode that writes a constant
// to every destination word at one cycle per word with no source reads.
module pr_dma_initiator
    import pr_dma_initiator_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             irq_clr,
`ifdef PR_DMA_FILL_EN
    input  logic             fill,
    input  logic [31:0]      fill_val,
`endif
    output logic [31:0]      PrAddr,
    output logic [31:0]      PrWD,
    output logic             PrWe,
    input  logic [31:0]      PrRD,
    output logic             busy,
    output logic             irq,
    output logic [LEN_W-1:0] words_done
);

    localparam logic [31:0] ADDR_STEP = 32'(WORD_BYTES);
    localparam logic [31:0] ALIGN_MSK = ~(ADDR_STEP - 32'd1);

    state_e           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] words_done_q, words_done_d;
    logic             irq_q, irq_d;
`ifdef PR_DMA_FILL_EN
    logic             fill_q, fill_d;
`endif

    // Next-state, address/count update and interrupt set/clear logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        data_d       = data_q;
        rem_d        = rem_q;
        words_done_d = words_done_q;
        irq_d        = irq_q;
`ifdef PR_DMA_FILL_EN
        fill_d       = fill_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Byte-address low bits are dropped; the bus is word addressed.
                    src_d        = src_addr & ALIGN_MSK;
                    dst_d        = dst_addr & ALIGN_MSK;
                    rem_d        = len;
                    words_done_d = '0;
`ifdef PR_DMA_FILL_EN
                    fill_d       = fill;
                    if (fill) begin
                        data_d = fill_val;
                    end
                    if (len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = fill ? WR : RD;
                    end
`else
                    state_d = (len == '0) ? FIN : RD;
`endif
                end
            end
            RD: begin
                data_d  = PrRD;
                src_d   = src_q + ADDR_STEP;
                state_d = WR;
            end
            WR: begin
                dst_d        = dst_q + ADDR_STEP;
                rem_d        = rem_q - LEN_W'(1);
                words_done_d = words_done_q + LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    state_d = FIN;
                end else begin
`ifdef PR_DMA_FILL_EN
                    state_d = fill_q ? WR : RD;
`else
                    state_d = RD;
`endif
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear first so a completion in the same cycle takes priority.
        if (irq_clr) begin
            irq_d = 1'b0;
        end
        if (state_q == FIN) begin
            irq_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            rem_q        <= '0;
            words_done_q <= '0;
            irq_q        <= 1'b0;
`ifdef PR_DMA_FILL_EN
            fill_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the pre-edge values, independent of statement order.
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
            words_done_q <= words_done_d;
            irq_q        <= irq_d;
`ifdef PR_DMA_FILL_EN
            fill_q       <= fill_d;
`endif
        end
    end

    // Bus outputs decoded from registered state only, so they are glitch-free.
    always_comb begin
        PrAddr = 32'd0;
        PrWD   = 32'd0;
        PrWe   = 1'b0;
        case (state_q)
            RD: begin
                PrAddr = src_q;
            end
            WR: begin
                PrAddr = dst_q;
                PrWD   = data_q;
                PrWe   = 1'b1;
            end
            default: begin
                PrAddr = 32'd0;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign irq        = irq_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_pr_dma_initiator.sv
// Directed self-checking bench for pr_dma_initiator.
// A combinational responder answers reads with 0xA0 + (PrAddr - 0x7F00).
module tb_pr_dma_initiator;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             irq_clr;
`ifdef PR_DMA_FILL_EN
    logic             fill;
    logic [31:0]      fill_val;
`endif
    logic [31:0]      PrAddr;
    logic [31:0]      PrWD;
    logic             PrWe;
    logic [31:0]      PrRD;
    logic             busy;
    logic             irq;
    logic [LEN_W-1:0] words_done;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wr_base;

    pr_dma_initiator #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .irq_clr    (irq_clr),
`ifdef PR_DMA_FILL_EN
        .fill       (fill),
        .fill_val   (fill_val),
`endif
        .PrAddr     (PrAddr),
        .PrWD       (PrWD),
        .PrWe       (PrWe),
        .PrRD       (PrRD),
        .busy       (busy),
        .irq        (irq),
        .words_done (words_done)
    );

    always #5 clk = ~clk;

    assign PrRD = 32'h0000_00A0 + (PrAddr - 32'h0000_7F00);

    // Counts writes that actually complete at a clock edge.
    always @(posedge clk) begin
        if (PrWe === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] n);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        irq_clr  = 1'b0;
`ifdef PR_DMA_FILL_EN
        fill     = 1'b0;
        fill_val = '0;
`endif
        tick();
        tick();
        check("rst_busy",   busy,       0);
        check("rst_irq",    irq,        0);
        check("rst_we",     PrWe,       0);
        check("rst_addr",   PrAddr,     0);
        check("rst_wd",     PrWD,       0);
        check("rst_wdone",  words_done, 0);
        reset = 1'b1;
        tick();

        // Copy of 3 words: writes on cycles 2, 4, 6; irq after cycle 7.
        issue(32'h7F00, 32'h7F10, 3);
        check("c3_rd1_addr", PrAddr, 32'h7F00);
        check("c3_rd1_we",   PrWe,   0);
        check("c3_busy",     busy,   1);
        tick();
        check("c3_wr1_we",   PrWe,   1);
        check("c3_wr1_addr", PrAddr, 32'h7F10);
        check("c3_wr1_wd",   PrWD,   32'hA0);
        tick();
        check("c3_rd2_addr", PrAddr, 32'h7F04);
        check("c3_rd2_we",   PrWe,   0);
        tick();
        check("c3_wr2_addr", PrAddr, 32'h7F14);
        check("c3_wr2_wd",   PrWD,   32'hA4);
        tick();
        check("c3_rd3_addr", PrAddr, 32'h7F08);
        tick();
        check("c3_wr3_addr", PrAddr, 32'h7F18);
        check("c3_wr3_wd",   PrWD,   32'hA8);
        check("c3_wr3_we",   PrWe,   1);
        check("c3_wdone2",   words_done, 2);
        tick();
        check("c3_fin_we",   PrWe,   0);
        check("c3_fin_busy", busy,   1);
        check("c3_fin_irq",  irq,    0);
        check("c3_wdone3",   words_done, 3);
        tick();
        check("c3_irq",      irq,    1);
        check("c3_idle",     busy,   0);
        check("c3_hold",     words_done, 3);
        clear_irq();
        check("c3_irq_clr",  irq,    0);

        // Zero-length transfer: no write, irq one cycle after start.
        wr_base = wr_count;
        issue(32'h7F00, 32'h7F10, 0);
        check("z_fin_busy",  busy,   1);
        check("z_fin_we",    PrWe,   0);
        check("z_wdone",     words_done, 0);
        check("z_irq_early", irq,    0);
        tick();
        check("z_irq",       irq,    1);
        check("z_idle",      busy,   0);
        check("z_no_write",  wr_count - wr_base, 0);
        clear_irq();
        check("z_irq_clr",   irq,    0);

        // Address wrap with misaligned low bits on the source.
        issue(32'hFFFF_FFFF, 32'h7F04, 2);
        check("w_rd1_addr",  PrAddr, 32'hFFFF_FFFC);
        tick();
        check("w_wr1_addr",  PrAddr, 32'h7F04);
        check("w_wr1_wd",    PrWD,   32'hFFFF_819C);
        tick();
        check("w_rd2_addr",  PrAddr, 32'h0000_0000);
        check("w_rd2_busy",  busy,   1);
        tick();
        check("w_wr2_addr",  PrAddr, 32'h7F08);
        check("w_wr2_wd",    PrWD,   32'hFFFF_81A0);
        tick();
        tick();
        check("w_irq",       irq,    1);
        check("w_wdone",     words_done, 2);
        clear_irq();

        // Start while busy is ignored; irq_clr coinciding with FIN loses.
        issue(32'h7F00, 32'h7F20, 1);
        dst_addr = 32'h7F80;
        len      = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("b_wr_addr",   PrAddr, 32'h7F20);
        check("b_wr_wd",     PrWD,   32'hA0);
        tick();
        check("b_fin_busy",  busy,   1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("b_set_wins",  irq,    1);
        check("b_idle",      busy,   0);
        check("b_wdone",     words_done, 1);
        tick();
        check("b_irq_hold",  irq,    1);
        clear_irq();
        check("b_irq_clr",   irq,    0);
        clear_irq();
        check("b_clr_noop",  irq,    0);

        // Asynchronous reset during the second of four writes.
        wr_base = wr_count;
        issue(32'h7F00, 32'h7F40, 4);
        tick();
        tick();
        tick();
        check("r_wr2_we",    PrWe,   1);
        check("r_wr2_addr",  PrAddr, 32'h7F44);
        reset = 1'b0;
        #1;
        check("r_we",        PrWe,   0);
        check("r_addr",      PrAddr, 0);
        check("r_wd",        PrWD,   0);
        check("r_busy",      busy,   0);
        check("r_wdone",     words_done, 0);
        check("r_irq",       irq,    0);
        tick();
        tick();
        check("r_one_write", wr_count - wr_base, 1);
        reset = 1'b1;
        tick();
        check("r_still_idle", busy,  0);

`ifdef PR_DMA_FILL_EN
        // Fill mode: four consecutive writes, no reads, irq after cycle 5.
        fill     = 1'b1;
        fill_val = 32'hDEAD_BEEF;
        wr_base  = wr_count;
        issue(32'h1234_5678, 32'h7F00, 4);
        fill     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("f_we",   PrWe,   1);
            check("f_addr", PrAddr, 32'h7F00 + 32'(4 * i));
            check("f_wd",   PrWD,   32'hDEAD_BEEF);
            tick();
        end
        check("f_fin_we",    PrWe,   0);
        check("f_fin_irq",   irq,    0);
        tick();
        check("f_irq",       irq,    1);
        check("f_wdone",     words_done, 4);
        check("f_writes",    wr_count - wr_base, 4);
        clear_irq();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
